afifo_wr_arbiter: RTL and testbench

//  Write-side controller for the async FIFO write port, in the wclk domain.

---
 rtl/afifo_wr_arbiter_pkg.sv | 11 +
 rtl/afifo_wr_arbiter_if.sv | 27 ++
 rtl/afifo_wr_arbiter_picker.sv | 43 ++++
 rtl/afifo_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_afifo_wr_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/afifo_wr_arbiter_pkg.sv
// Shared types and limits for the async FIFO write-side arbiter.
package afifo_wr_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } arb_state_t;

    localparam int unsigned ARB_MAX_REQ = 8;

endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// Requester / FIFO write-port bundle for afifo_wr_arbiter.
// master = requesters + FIFO side, slave = the arbiter.
interface afifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          full;
    logic                          winc;
    logic [DATA_WIDTH-1:0]         wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic                          busy;
    logic                          timeout_err;

    modport master (
        output req_valid, req_last, req_data, full,
        input  req_ready, winc, wdata, gnt, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_last, req_data, full,
        output req_ready, winc, wdata, gnt, busy, timeout_err
    );
endinterface

// File: rtl/afifo_wr_arbiter_picker.sv
// Combinational round-robin picker: first unmasked request at or after ptr (cyclic).
module flex_rr_picker
    import afifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic [N-1:0]         mask,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int unsigned PW = $clog2(N);

    if (N < 2 || N > ARB_MAX_REQ) begin : g_bad_n
        $error("flex_rr_picker: N out of range");
    end

    int unsigned      cand;
    logic [PW-1:0]    cand_idx;

    // Scan N positions starting at ptr, wrapping explicitly for non-power-of-2 N.
    always_comb begin
        onehot   = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = PW'(cand);
            if (!any && req[cand_idx] && !mask[cand_idx]) begin
                any              = 1'b1;
                onehot[cand_idx] = 1'b1;
                idx              = cand_idx;
            end
        end
    end
endmodule

// File: rtl/afifo_wr_arbiter.sv
// Write-domain controller sharing one async FIFO write port among NUM_REQ
// requesters: round-robin with burst locking, full back-pressure, and a
// watchdog that releases an owner stalled mid-burst.
module afifo_wr_arbiter
    import afifo_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input logic               wclk,
    input logic               w_nrst,
    afifo_wr_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned WW = $clog2(TIMEOUT_CYC);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("afifo_wr_arbiter: TIMEOUT_CYC must be >= 2");
    end

    arb_state_t            state;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [PW-1:0]         owner;
    logic [PW-1:0]         rr_ptr;
    logic [WW-1:0]         wdog;
    logic                  timeout_q;

    logic                  lock;
    logic                  own_valid;
    logic                  own_last;
    logic                  xfer;
    logic [PW-1:0]         nxt_ptr;
    logic [PW-1:0]         pick_ptr;
    logic [NUM_REQ-1:0]    pick_mask;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic [PW-1:0]         pick_idx;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] wdata_c;

    // One picker serves both IDLE arbitration and same-edge re-arbitration
    // after a last beat; in LOCK it starts after the owner and masks it out.
    always_comb begin
        lock      = (state == ARB_LOCK);
        own_valid = bus.req_valid[owner];
        own_last  = bus.req_last[owner];
        xfer      = lock && own_valid && !bus.full;
        nxt_ptr   = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        pick_ptr  = lock ? nxt_ptr : rr_ptr;
        pick_mask = lock ? gnt_q : '0;
    end

    flex_rr_picker #(
        .N(NUM_REQ)
    ) u_picker (
        .req    (bus.req_valid),
        .ptr    (pick_ptr),
        .mask   (pick_mask),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // AND-OR data mux keyed by the registered grant; reads zero when idle.
    always_comb begin
        wdata_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                wdata_c = wdata_c | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.req_ready   = bus.full ? '0 : gnt_q;
    assign bus.winc        = xfer;
    assign bus.wdata       = wdata_c;
    assign bus.gnt         = gnt_q;
    assign bus.busy        = lock;
    assign bus.timeout_err = timeout_q;

    // Arbitration FSM with round-robin pointer and stall watchdog.
    always_ff @(posedge wclk or negedge w_nrst) begin
        if (!w_nrst) begin
            state     <= ARB_IDLE;
            gnt_q     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state <= ARB_LOCK;
                        gnt_q <= pick_onehot;
                        owner <= pick_idx;
                        wdog  <= '0;
                    end
                end
                ARB_LOCK: begin
                    if (xfer && own_last) begin
                        rr_ptr <= nxt_ptr;
                        wdog   <= '0;
                        if (pick_any) begin
                            gnt_q <= pick_onehot;
                            owner <= pick_idx;
                        end else begin
                            state <= ARB_IDLE;
                            gnt_q <= '0;
                        end
                    end else if (own_valid) begin
                        wdog <= '0;
                    end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
                        // wdog stays saturated; it is cleared on the next grant.
                        state     <= ARB_IDLE;
                        gnt_q     <= '0;
                        rr_ptr    <= nxt_ptr;
                        timeout_q <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Directed bench for afifo_wr_arbiter: vector table for bursts, fairness and
// back-pressure, plus hand sequences for watchdog, async reset and NUM_REQ=3.
module tb_afifo_wr_arbiter;

    logic wclk;
    logic w_nrst;

    int checks = 0;
    int errors = 0;

    afifo_wr_arbiter_if #(.NUM_REQ(2), .DATA_WIDTH(32)) b2();
    afifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(8))  b3();

    afifo_wr_arbiter #(
        .NUM_REQ     (2),
        .DATA_WIDTH  (32),
        .TIMEOUT_CYC (16)
    ) dut2 (
        .wclk   (wclk),
        .w_nrst (w_nrst),
        .bus    (b2)
    );

    afifo_wr_arbiter #(
        .NUM_REQ     (3),
        .DATA_WIDTH  (8),
        .TIMEOUT_CYC (16)
    ) dut3 (
        .wclk   (wclk),
        .w_nrst (w_nrst),
        .bus    (b3)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  l;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        full;
        logic [1:0]  gnt;
        logic [1:0]  rdy;
        logic        winc;
        logic [31:0] wdata;
        logic        busy;
        logic        terr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk2(input string tag, input logic [1:0] gnt, input logic winc,
                        input logic busy, input logic terr);
        chk({tag, " gnt"},  64'(b2.gnt), 64'(gnt));
        chk({tag, " winc"}, 64'(b2.winc), 64'(winc));
        chk({tag, " busy"}, 64'(b2.busy), 64'(busy));
        chk({tag, " terr"}, 64'(b2.timeout_err), 64'(terr));
    endtask

    logic [2:0] g3_exp [4];
    logic [7:0] d3_exp [4];

    initial begin
        //                v      l      d0            d1            full  gnt    rdy    winc  wdata         busy  terr
        // single 3-beat burst from req0
        vq.push_back('{2'b01, 2'b00, 32'ha0000001, 32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0});
        vq.push_back('{2'b01, 2'b00, 32'ha0000001, 32'h0,        1'b0, 2'b01, 2'b01, 1'b1, 32'ha0000001, 1'b1, 1'b0});
        vq.push_back('{2'b01, 2'b00, 32'ha0000002, 32'h0,        1'b0, 2'b01, 2'b01, 1'b1, 32'ha0000002, 1'b1, 1'b0});
        vq.push_back('{2'b01, 2'b01, 32'ha0000003, 32'h0,        1'b0, 2'b01, 2'b01, 1'b1, 32'ha0000003, 1'b1, 1'b0});
        vq.push_back('{2'b00, 2'b00, 32'h0,        32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0});
        // fairness: rr_ptr now 1, both valid, 1-beat bursts
        vq.push_back('{2'b11, 2'b11, 32'hb0000001, 32'hc0000001, 1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0});
        vq.push_back('{2'b11, 2'b11, 32'hb0000001, 32'hc0000001, 1'b0, 2'b10, 2'b10, 1'b1, 32'hc0000001, 1'b1, 1'b0});
        vq.push_back('{2'b11, 2'b11, 32'hb0000001, 32'hc0000002, 1'b0, 2'b01, 2'b01, 1'b1, 32'hb0000001, 1'b1, 1'b0});
        vq.push_back('{2'b11, 2'b11, 32'hb0000002, 32'hc0000002, 1'b0, 2'b10, 2'b10, 1'b1, 32'hc0000002, 1'b1, 1'b0});
        vq.push_back('{2'b01, 2'b01, 32'hb0000002, 32'h0,        1'b0, 2'b01, 2'b01, 1'b1, 32'hb0000002, 1'b1, 1'b0});
        // back-pressure: full for 4 cycles mid-burst
        vq.push_back('{2'b01, 2'b00, 32'hd0000001, 32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0});
        vq.push_back('{2'b01, 2'b00, 32'hd0000001, 32'h0,        1'b0, 2'b01, 2'b01, 1'b1, 32'hd0000001, 1'b1, 1'b0});
        for (int i = 0; i < 4; i++)
            vq.push_back('{2'b01, 2'b00, 32'hd0000002, 32'h0,    1'b1, 2'b01, 2'b00, 1'b0, 32'hd0000002, 1'b1, 1'b0});
        vq.push_back('{2'b01, 2'b00, 32'hd0000002, 32'h0,        1'b0, 2'b01, 2'b01, 1'b1, 32'hd0000002, 1'b1, 1'b0});
        vq.push_back('{2'b01, 2'b01, 32'hd0000003, 32'h0,        1'b0, 2'b01, 2'b01, 1'b1, 32'hd0000003, 1'b1, 1'b0});
        vq.push_back('{2'b00, 2'b00, 32'h0,        32'h0,        1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 1'b0});

        g3_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        d3_exp = '{8'h10, 8'h11, 8'h12, 8'h10};

        // reset state
        w_nrst       = 1'b0;
        b2.req_valid = '0;
        b2.req_last  = '0;
        b2.req_data  = '0;
        b2.full      = 1'b0;
        b3.req_valid = '0;
        b3.req_last  = '0;
        b3.req_data  = '0;
        b3.full      = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        chk2("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("reset rdy", 64'(b2.req_ready), 64'h0);
        w_nrst = 1'b1;

        // table-driven vectors
        for (int i = 0; i < vq.size(); i++) begin
            b2.req_valid = vq[i].v;
            b2.req_last  = vq[i].l;
            b2.req_data  = {vq[i].d1, vq[i].d0};
            b2.full      = vq[i].full;
            #2;
            chk2($sformatf("vec%0d", i), vq[i].gnt, vq[i].winc, vq[i].busy, vq[i].terr);
            chk($sformatf("vec%0d rdy", i),   64'(b2.req_ready), 64'(vq[i].rdy));
            chk($sformatf("vec%0d wdata", i), 64'(b2.wdata),     64'(vq[i].wdata));
            tick();
        end

        // watchdog: req1 locked (rr_ptr=1), then stalls while req0 waits
        b2.req_valid = 2'b10;
        b2.req_last  = 2'b00;
        b2.req_data  = {32'he0000001, 32'hf0000001};
        #2;
        chk2("wd idle", 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        chk2("wd grant", 2'b10, 1'b1, 1'b1, 1'b0);
        chk("wd wdata", 64'(b2.wdata), 64'he0000001);
        tick();
        b2.req_valid = 2'b01;
        b2.req_last  = 2'b01;
        for (int j = 1; j <= 16; j++) begin
            #2;
            chk2($sformatf("wd stall%0d", j), 2'b10, 1'b0, 1'b1, 1'b0);
            tick();
        end
        #2;
        chk2("wd release", 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        #2;
        chk2("wd regrant", 2'b01, 1'b1, 1'b1, 1'b0);
        chk("wd regrant wdata", 64'(b2.wdata), 64'hf0000001);
        tick();
        b2.req_valid = 2'b00;
        #2;
        chk2("wd done", 2'b00, 1'b0, 1'b0, 1'b0);

        // async reset mid-burst (rr_ptr=1 before reset)
        tick();
        b2.req_valid = 2'b10;
        b2.req_last  = 2'b00;
        b2.req_data  = {32'h60000001, 32'h70000001};
        tick();
        #2;
        chk2("rst pre", 2'b10, 1'b1, 1'b1, 1'b0);
        #2;
        w_nrst = 1'b0;
        #1;
        chk2("rst async", 2'b00, 1'b0, 1'b0, 1'b0);
        chk("rst async rdy", 64'(b2.req_ready), 64'h0);
        tick();
        chk2("rst held", 2'b00, 1'b0, 1'b0, 1'b0);
        w_nrst       = 1'b1;
        b2.req_valid = 2'b11;
        b2.req_last  = 2'b01;
        #2;
        chk2("rst idle", 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        #2;
        chk2("rst req0 first", 2'b01, 1'b1, 1'b1, 1'b0);
        chk("rst req0 wdata", 64'(b2.wdata), 64'h70000001);
        tick();
        b2.req_valid = 2'b10;
        b2.req_last  = 2'b10;
        #2;
        chk2("rst req1 next", 2'b10, 1'b1, 1'b1, 1'b0);
        chk("rst req1 wdata", 64'(b2.wdata), 64'h60000001);
        tick();
        b2.req_valid = 2'b00;
        #2;
        chk2("rst done", 2'b00, 1'b0, 1'b0, 1'b0);

        // NUM_REQ=3, all valid: 0,1,2,0 with pointer wrap
        b3.req_valid = 3'b111;
        b3.req_last  = 3'b111;
        b3.req_data  = {8'h12, 8'h11, 8'h10};
        #2;
        chk("n3 idle gnt", 64'(b3.gnt), 64'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) b3.req_valid = 3'b001;
            #2;
            chk($sformatf("n3 gnt%0d", k),   64'(b3.gnt),   64'(g3_exp[k]));
            chk($sformatf("n3 winc%0d", k),  64'(b3.winc),  64'h1);
            chk($sformatf("n3 wdata%0d", k), 64'(b3.wdata), 64'(d3_exp[k]));
            tick();
        end
        b3.req_valid = 3'b000;
        #2;
        chk("n3 end gnt",  64'(b3.gnt),  64'h0);
        chk("n3 end busy", 64'(b3.busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
